// File: rtl/bcd_updown_counter_pkg.sv
// rtl/bcd_updown_counter_pkg.sv - BCD digit constants and per-digit arithmetic helpers
package bcd_updown_counter_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // The 7-segment decoder has no pattern for 10-15, so anything above 9 is pinned to 9.
    function automatic logic [BCD_W-1:0] bcdClamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic [BCD_W-1:0] bcdInc(input logic [BCD_W-1:0] d);
        return (d >= BCD_MAX) ? BCD_ZERO : d + BCD_W'(1);
    endfunction

    function automatic logic [BCD_W-1:0] bcdDec(input logic [BCD_W-1:0] d);
        return (d == BCD_ZERO) ? BCD_MAX : d - BCD_W'(1);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with load/clear and ripple carry/borrow out
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic             Clk,
    input  logic             nReset,
    input  logic             step_in,
    input  logic             Up,
    input  logic             Load,
    input  logic             Clear,
    input  logic [BCD_W-1:0] loadDigit,
    output logic [BCD_W-1:0] digit,
    output logic             step_out
);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            digit <= BCD_ZERO;
        end else if (Load) begin
            digit <= bcdClamp(loadDigit);
        end else if (Clear) begin
            digit <= BCD_ZERO;
        end else if (step_in) begin
            digit <= Up ? bcdInc(digit) : bcdDec(digit);
        end
    end

    assign step_out = step_in && (Up ? (digit == BCD_MAX) : (digit == BCD_ZERO));

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - prescaled multi-digit BCD up/down counter; BCD_CNT_SATURATE_EN selects saturation
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int NDIGITS  = 2,
    parameter int PRESCALE = 50000000,
    parameter int PS_W     = 26
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic                     Enable,
    input  logic                     Up,
    input  logic                     Clear,
    input  logic                     Load,
    input  logic [BCD_W*NDIGITS-1:0] LoadVal,
    output logic [BCD_W*NDIGITS-1:0] BcdOut,
    output logic                     Tick,
    output logic                     Carry,
    output logic                     Borrow,
    output logic                     Zero
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] psCnt;
    logic            stepReq;
    logic            stepFirst;
    logic            wrapNow;
    logic [NDIGITS:0] ripple;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            psCnt <= '0;
            Tick  <= 1'b0;
        end else begin
            Tick  <= (psCnt == PS_LAST);
            psCnt <= (psCnt == PS_LAST) ? '0 : psCnt + PS_W'(1);
        end
    end

    // Load and Clear outrank a step, so a step never reaches the flags when either is active.
    assign stepReq = Tick && Enable && !Load && !Clear;

`ifdef BCD_CNT_SATURATE_EN
    localparam logic [BCD_W*NDIGITS-1:0] ALL_NINES = {NDIGITS{BCD_MAX}};
    logic atLimit;

    assign atLimit   = Up ? (BcdOut == ALL_NINES) : (BcdOut == '0);
    assign wrapNow   = stepReq && atLimit;
    assign stepFirst = stepReq && !atLimit;
`else
    assign stepFirst = stepReq;
    assign wrapNow   = ripple[NDIGITS];
`endif

    assign ripple[0] = stepFirst;

    for (genvar g = 0; g < NDIGITS; g++) begin : gDigit
        bcd_digit uDigit (
            .Clk       (Clk),
            .nReset    (nReset),
            .step_in   (ripple[g]),
            .Up        (Up),
            .Load      (Load),
            .Clear     (Clear),
            .loadDigit (LoadVal[g*BCD_W +: BCD_W]),
            .digit     (BcdOut[g*BCD_W +: BCD_W]),
            .step_out  (ripple[g+1])
        );
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Carry  <= 1'b0;
            Borrow <= 1'b0;
        end else begin
            Carry  <= wrapNow && Up;
            Borrow <= wrapNow && !Up;
        end
    end

    assign Zero = (BcdOut == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter (NDIGITS=2, PRESCALE=4)
module tb_bcd_updown_counter;

    localparam int NDIGITS  = 2;
    localparam int PRESCALE = 4;
    localparam int PS_W     = 2;
    localparam int MAXV     = 99;
`ifdef BCD_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       nReset;
    logic       Enable, Up, Clear, Load;
    logic [7:0] LoadVal;
    logic [7:0] BcdOut;
    logic       Tick, Carry, Borrow, Zero;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    bcd_updown_counter #(
        .NDIGITS  (NDIGITS),
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) dut (
        .Clk     (Clk),
        .nReset  (nReset),
        .Enable  (Enable),
        .Up      (Up),
        .Clear   (Clear),
        .Load    (Load),
        .LoadVal (LoadVal),
        .BcdOut  (BcdOut),
        .Tick    (Tick),
        .Carry   (Carry),
        .Borrow  (Borrow),
        .Zero    (Zero)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] toBcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int loadDecimal(input logic [7:0] lv);
        int u;
        int t;
        u = int'(lv[3:0]);
        t = int'(lv[7:4]);
        if (u > 9) u = 9;
        if (t > 9) t = 9;
        return t * 10 + u;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count held as a plain integer 0..99, tick derived from cycles since reset.
    int mCyc    = 0;
    bit mTick   = 1'b0;
    int mVal    = 0;
    bit mCarry  = 1'b0;
    bit mBorrow = 1'b0;

    always @(posedge Clk or negedge nReset) begin
        int nv;
        bit wrapped;
        if (!nReset) begin
            mCyc    <= 0;
            mTick   <= 1'b0;
            mVal    <= 0;
            mCarry  <= 1'b0;
            mBorrow <= 1'b0;
        end else begin
            nv = mVal;
            wrapped = 1'b0;
            if (Load) begin
                nv = loadDecimal(LoadVal);
            end else if (Clear) begin
                nv = 0;
            end else if (mTick && Enable) begin
                if (Up) begin
                    if (mVal == MAXV) begin
                        wrapped = 1'b1;
                        nv = SAT ? MAXV : 0;
                    end else begin
                        nv = mVal + 1;
                    end
                end else begin
                    if (mVal == 0) begin
                        wrapped = 1'b1;
                        nv = SAT ? 0 : MAXV;
                    end else begin
                        nv = mVal - 1;
                    end
                end
            end
            mCyc    <= mCyc + 1;
            mTick   <= ((mCyc + 1) % PRESCALE) == 0;
            mVal    <= nv;
            mCarry  <= wrapped && Up;
            mBorrow <= wrapped && !Up;
        end
    end

    always @(negedge Clk) begin
        if (checkOn) begin
            check("model BcdOut", 32'(BcdOut), 32'(toBcd(mVal)));
            check("model Tick", 32'(Tick), 32'(mTick));
            check("model Carry", 32'(Carry), 32'(mCarry));
            check("model Borrow", 32'(Borrow), 32'(mBorrow));
            check("model Zero", 32'(Zero), 32'(mVal == 0));
        end
    end

    task automatic waitTick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (Tick === 1'b1) seen = 1'b1;
            else @(negedge Clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL waitTick: got no Tick, expected one within 12 cycles at %0t", $time);
        end
    endtask

    task automatic loadValue(input logic [7:0] v);
        LoadVal = v;
        Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    logic [7:0] downExp [6];
    int carryCount;
    int tickCount;
    int firstTick;
    int lastTick;
    int k;

    initial begin
        nReset = 1'b0;
        Enable = 1'b0;
        Up = 1'b1;
        Clear = 1'b0;
        Load = 1'b0;
        LoadVal = 8'h00;
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        checkOn = 1'b1;

        // Reset mid-count at 37
        loadValue(8'h37);
        repeat (2) @(negedge Clk);
        check("pre-reset value", 32'(BcdOut), 32'h37);
        nReset = 1'b0;
        #1;
        check("async reset BcdOut", 32'(BcdOut), 32'h00);
        repeat (3) @(negedge Clk);
        check("reset Zero", 32'(Zero), 32'd1);
        check("reset Carry", 32'(Carry), 32'd0);
        check("reset Borrow", 32'(Borrow), 32'd0);
        check("reset Tick", 32'(Tick), 32'd0);
        nReset = 1'b1;
        k = 0;
        while (Tick !== 1'b1 && k < 10) begin
            @(negedge Clk);
            k++;
        end
        check("first tick latency", 32'(k), 32'd4);

        // Up count through a full wrap
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        Enable = 1'b1;
        Up = 1'b1;
        carryCount = 0;
        for (int i = 0; i < 100; i++) begin
            waitTick();
            @(negedge Clk);
            if (Carry === 1'b1) carryCount++;
            if (i == 9) check("up tick 10", 32'(BcdOut), 32'h10);
            if (i == 98) check("up tick 99", 32'(BcdOut), 32'h99);
        end
        check("up wrap value", 32'(BcdOut), SAT ? 32'h99 : 32'h00);
        check("up carry count", 32'(carryCount), 32'd1);

        // Down count from 05 across 00
        downExp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, SAT ? 8'h00 : 8'h99};
        Enable = 1'b0;
        Up = 1'b0;
        loadValue(8'h05);
        Enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            waitTick();
            @(negedge Clk);
            check("down value", 32'(BcdOut), 32'(downExp[i]));
            check("down borrow", 32'(Borrow), (i == 5) ? 32'd1 : 32'd0);
        end

        // Priority: Load beats Clear beats a carrying step
        Enable = 1'b0;
        Up = 1'b1;
        loadValue(8'h99);
        waitTick();
        Load = 1'b1;
        Clear = 1'b1;
        LoadVal = 8'h42;
        Enable = 1'b1;
        @(negedge Clk);
        check("priority load", 32'(BcdOut), 32'h42);
        check("priority no carry", 32'(Carry), 32'd0);
        Load = 1'b0;
        @(negedge Clk);
        check("clear alone", 32'(BcdOut), 32'h00);
        Clear = 1'b0;
        Enable = 1'b0;

        // Invalid load values clamp per digit
        loadValue(8'hAF);
        check("load AF", 32'(BcdOut), 32'h99);
        for (int v = 0; v < 256; v++) begin
            LoadVal = 8'(v);
            Load = 1'b1;
            @(negedge Clk);
            check("sweep units<=9", 32'(BcdOut[3:0] <= 4'd9), 32'd1);
            check("sweep tens<=9", 32'(BcdOut[7:4] <= 4'd9), 32'd1);
        end
        Load = 1'b0;

        // Enable gating at 17
        loadValue(8'h17);
        tickCount = 0;
        firstTick = -1;
        lastTick = -1;
        for (int c = 0; c < 32; c++) begin
            @(negedge Clk);
            if (Tick === 1'b1) begin
                if (firstTick < 0) firstTick = c;
                lastTick = c;
                tickCount++;
            end
        end
        check("gated tick count", 32'(tickCount), 32'd8);
        check("gated tick spacing", 32'(lastTick - firstTick), 32'd28);
        check("gated hold", 32'(BcdOut), 32'h17);

        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
